// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - op code localparams for the 3-bit op_E field
//   - IDLE/RUN state encoding
//   - cnt_width(): width of the latency counter, $clog2(max(MUL_LAT, DIV_LAT) + 1)
package mdu_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MSUB  = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic int cnt_width(input int mul_lat, input int div_lat);
        int max_lat;
        max_lat = (mul_lat > div_lat) ? mul_lat : div_lat;
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: EX-stage issue bus of the multiply/divide unit.
//   start, op_E, SrcA_E, SrcB_E : issue side (driven by the pipeline)
//   busy, HI, LO                : unit side (driven by the unit, straight from registers)
// Handshake: start is a single-cycle issue strobe taken only while busy is low.
// The unit has no ready signal; busy high means a long op is in flight and the
// pipeline must hold back anything that touches HI/LO. A start seen while busy
// is dropped, never queued.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op_E;
    logic [WIDTH-1:0] SrcA_E;
    logic [WIDTH-1:0] SrcB_E;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, op_E, SrcA_E, SrcB_E,
        input  busy, HI, LO
    );

    modport slave (
        input  start, op_E, SrcA_E, SrcB_E,
        output busy, HI, LO
    );
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational result generator for the multiply/divide unit.
//   op      : op code (mdu_pkg)
//   a, b    : rs / rt operands
//   hi, lo  : current HI/LO (accumulate base, and kept value on divide-by-zero)
//   res_hi, res_lo : result to be committed to HI/LO
// Config macro MULT_DIV_MADD_EN enables the MADD/MSUB accumulate results;
// without it those op codes return HI/LO unchanged.
module mdu_arith
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag;
    logic [WIDTH-1:0]   q_s, r_s;
    logic               a_neg, b_neg, div_zero, div_ovf;

    assign a_neg = a[WIDTH-1];
    assign b_neg = b[WIDTH-1];

    // Sign-extend to full product width so the truncated 2W product is exact.
    assign prod_s = $signed({{WIDTH{a_neg}}, a}) * $signed({{WIDTH{b_neg}}, b});
    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide through magnitudes: the quotient is negated when the signs
    // differ (truncation toward zero), the remainder follows the dividend.
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign q_s   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
    assign r_s   = a_neg ? (~r_mag + 1'b1) : r_mag;

    assign div_zero = (b == '0);
    assign div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    always_comb begin
        res_hi = hi;
        res_lo = lo;
        case (op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV: begin
                if (div_ovf) begin
                    res_lo = a;
                    res_hi = '0;
                end else if (!div_zero) begin
                    res_lo = q_s;
                    res_hi = r_s;
                end
            end
            OP_DIVU: begin
                if (!div_zero) begin
                    res_lo = a / b;
                    res_hi = a % b;
                end
            end
`ifdef MULT_DIV_MADD_EN
            OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
            OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : mult_div_unit_if.slave (start/op_E/SrcA_E/SrcB_E in, busy/HI/LO out)
//   state_dbg  : current FSM state (IDLE/RUN) for observation
// The result is computed at issue and held in res_hi/res_lo; HI/LO are only
// written at the commit edge (LAT edges after issue) or by MTHI/MTLO in IDLE.
// Config macro MULT_DIV_MADD_EN makes MADD/MSUB long ops; otherwise they are no-ops.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    mult_div_unit_if.slave        bus,
    output state_t                state_dbg
);
    localparam int CW = cnt_width(MUL_LAT, DIV_LAT);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, res_hi_q, res_lo_q;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             is_long, is_div, issue, last;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (bus.op_E),
        .a      (bus.SrcA_E),
        .b      (bus.SrcB_E),
        .hi     (hi_q),
        .lo     (lo_q),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    always_comb begin
        is_long = 1'b0;
        is_div  = 1'b0;
        case (bus.op_E)
            OP_MULT, OP_MULTU: is_long = 1'b1;
            OP_DIV, OP_DIVU: begin
                is_long = 1'b1;
                is_div  = 1'b1;
            end
`ifdef MULT_DIV_MADD_EN
            OP_MADD, OP_MSUB: is_long = 1'b1;
`endif
            default: ;
        endcase
    end

    assign issue = bus.start && is_long && (state_q == S_IDLE);
    assign last  = (state_q == S_RUN) && (cnt_q == CW'(1));

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (issue) state_d = S_RUN;
            S_RUN:  if (last)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
        end else if (issue) begin
            res_hi_q <= res_hi;
            res_lo_q <= res_lo;
            cnt_q    <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (state_q == S_RUN) begin
            cnt_q <= cnt_q - 1'b1;
            if (last) begin
                hi_q <= res_hi_q;
                lo_q <= res_lo_q;
            end
        end else if (bus.start) begin
            // IDLE and not a long op: only the MT writes have an effect.
            if (bus.op_E == OP_MTHI) hi_q <= bus.SrcA_E;
            if (bus.op_E == OP_MTLO) lo_q <= bus.SrcA_E;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed bench for mult_div_unit (WIDTH=32, MUL_LAT=5, DIV_LAT=10).
// Covers reset, MULT/MULTU/DIV/DIVU results and busy length, overflow and
// divide-by-zero, MT writes, start-while-busy, reset abort, and MADD/MSUB
// (behaviour selected by MULT_DIV_MADD_EN).
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic   clk = 1'b0;
    logic   reset;
    state_t state_dbg;
    int     errors = 0;
    int     checks = 0;
    int     n;

    mult_div_unit_if #(.WIDTH(W)) bus ();

    mult_div_unit #(.WIDTH(W), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one start strobe across a single rising edge; returns at the
    // following falling edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op_E   = op;
        bus.SrcA_E = a;
        bus.SrcB_E = b;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    // Count busy cycles until busy drops, bounded so a stuck busy cannot hang.
    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.op_E   = 3'b000;
        bus.SrcA_E = '0;
        bus.SrcB_E = '0;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_hi", bus.HI, 32'h0);
        check("rst_lo", bus.LO, 32'h0);
        check("rst_state", {31'b0, state_dbg}, {31'b0, S_IDLE});
        reset = 1'b0;

        // MULT -3 * 7
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        check("mult_state_run", {31'b0, state_dbg}, {31'b0, S_RUN});
        check("mult_hi_hold", bus.HI, 32'h0);
        wait_idle(n);
        check("mult_busy_len", n, 32'd5);
        check("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO, 32'hFFFF_FFEB);

        // MULTU max * max
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle(n);
        check("multu_busy_len", n, 32'd5);
        check("multu_hi", bus.HI, 32'hFFFF_FFFE);
        check("multu_lo", bus.LO, 32'h0000_0001);

        // DIVU 100 / 7
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_idle(n);
        check("divu_busy_len", n, 32'd10);
        check("divu_lo", bus.LO, 32'd14);
        check("divu_hi", bus.HI, 32'd2);

        // DIV -7 / 2
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        check("div_neg_lo", bus.LO, 32'hFFFF_FFFD);
        check("div_neg_hi", bus.HI, 32'hFFFF_FFFF);

        // DIV 7 / -2: quotient negative, remainder follows the positive dividend
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle(n);
        check("div_negb_lo", bus.LO, 32'hFFFF_FFFD);
        check("div_negb_hi", bus.HI, 32'd1);

        // Signed overflow
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        check("div_ovf_lo", bus.LO, 32'h8000_0000);
        check("div_ovf_hi", bus.HI, 32'h0);

        // Divide by zero keeps HI/LO but still runs the full latency
        issue(OP_DIV, 32'd5, 32'd0);
        wait_idle(n);
        check("div0_busy_len", n, 32'd10);
        check("div0_lo", bus.LO, 32'h8000_0000);
        check("div0_hi", bus.HI, 32'h0);

        // MTHI in IDLE
        issue(OP_MTHI, 32'h1234_5678, 32'h0);
        check("mthi_hi", bus.HI, 32'h1234_5678);
        check("mthi_busy", {31'b0, bus.busy}, 32'h0);
        check("mthi_lo", bus.LO, 32'h8000_0000);

        // MTLO while busy is ignored
        issue(OP_MULT, 32'd2, 32'd3);
        bus.start  = 1'b1;
        bus.op_E   = OP_MTLO;
        bus.SrcA_E = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start  = 1'b0;
        wait_idle(n);
        check("mtlo_busy_len", n, 32'd4);
        check("mtlo_busy_lo", bus.LO, 32'd6);
        check("mtlo_busy_hi", bus.HI, 32'd0);

        // Reset during the third busy cycle of a DIV
        issue(OP_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'b0, bus.busy}, 32'h0);
        check("abort_hi", bus.HI, 32'h0);
        check("abort_lo", bus.LO, 32'h0);
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_late_lo", bus.LO, 32'h0);
        check("abort_late_busy", {31'b0, bus.busy}, 32'h0);

        // MADD / MSUB
        issue(OP_MTLO, 32'd10, 32'h0);
        check("mtlo_lo", bus.LO, 32'd10);
`ifdef MULT_DIV_MADD_EN
        issue(OP_MADD, 32'd3, 32'd4);
        wait_idle(n);
        check("madd_busy_len", n, 32'd5);
        check("madd_lo", bus.LO, 32'd22);
        check("madd_hi", bus.HI, 32'd0);
        issue(OP_MSUB, 32'd5, 32'd5);
        wait_idle(n);
        check("msub_busy_len", n, 32'd5);
        check("msub_lo", bus.LO, 32'hFFFF_FFFD);
        check("msub_hi", bus.HI, 32'hFFFF_FFFF);
`else
        issue(OP_MADD, 32'd3, 32'd4);
        check("madd_off_busy", {31'b0, bus.busy}, 32'h0);
        repeat (6) @(negedge clk);
        check("madd_off_lo", bus.LO, 32'd10);
        check("madd_off_hi", bus.HI, 32'd0);
        issue(OP_MSUB, 32'd5, 32'd5);
        check("msub_off_busy", {31'b0, bus.busy}, 32'h0);
        repeat (6) @(negedge clk);
        check("msub_off_lo", bus.LO, 32'd10);
        check("msub_off_hi", bus.HI, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
